stopwatch_ctrl: RTL and testbench

// - Mode sequencer for the 4-digit BCD stopwatch/timer datapath (AB:CD, 7-seg display).
// - Decodes debounced start/stop and load buttons and generates the 10 ms count tick.
// - Drives counter enable, direction, load and clear; raises the timer-expired alarm.
// - Runs the digit-scan select for the display mux. Sits between the debouncers and the BCD counter.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/sw_prescaler.sv | 44 ++++
 rtl/stopwatch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch mode sequencer: FSM state codes,
// display anode patterns and digit indices.
package stopwatch_pkg;

    typedef logic [1:0] sw_state_t;

    localparam sw_state_t ST_IDLE    = 2'd0;
    localparam sw_state_t ST_RUN     = 2'd1;
    localparam sw_state_t ST_PAUSE   = 2'd2;
    localparam sw_state_t ST_EXPIRED = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [1:0] DIG_D = 2'd0;
    localparam logic [1:0] DIG_C = 2'd1;
    localparam logic [1:0] DIG_B = 2'd2;
    localparam logic [1:0] DIG_A = 2'd3;

    function automatic logic [3:0] an_pattern(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/sw_prescaler.sv
// Modulo-DIV enable prescaler: one-cycle tick at count DIV-1, then wraps to 0.
// A synchronous clear overrides counting.
module sw_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, then wrap on terminal count, then advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch/timer mode sequencer: button edge detect, IDLE/RUN/PAUSE/EXPIRED FSM,
// count tick generation, expiry blink and display digit scan. All outputs registered.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned BLINK_TK = 50,
    parameter int unsigned UP_WRAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       load_btn,
    input  logic       load_zero,
    input  logic       cnt_zero,
    input  logic       cnt_max,
    output logic       cnt_en,
    output logic       cnt_down,
    output logic       cnt_load,
    output logic       cnt_clr,
    output logic       alarm,
    output logic [1:0] digit_sel,
    output logic [3:0] an,
    output logic [2:0] state_o
);

    localparam int unsigned BW = (BLINK_TK > 1) ? $clog2(BLINK_TK) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TK - 1);
    localparam bit STOP_AT_MAX = (UP_WRAP == 0);

    logic          start_q, load_q;
    logic          rise_start, rise_load;
    sw_state_t     state_q, state_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_load_q, cnt_load_d;
    logic          cnt_down_q, cnt_down_d;
    logic          cnt_clr_q, alarm_q;
    logic [1:0]    dsel_q, dsel_d;
    logic [3:0]    an_q, an_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blank_q, blank_d;
    logic          tick, scan_tick, presc_en, presc_clr;

    // A simultaneous start rise suppresses the load rise.
    assign rise_start = start_btn & ~start_q;
    assign rise_load  = load_btn & ~load_q & ~rise_start;

    assign presc_en  = (state_q == ST_RUN) || (state_q == ST_EXPIRED);
    assign presc_clr = (state_d != state_q) && ((state_d == ST_RUN) || (state_d == ST_EXPIRED));

    sw_prescaler #(.DIV(TICK_DIV)) u_tick_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    sw_prescaler #(.DIV(SCAN_DIV)) u_scan_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .en   (1'b1),
        .tick (scan_tick)
    );

    // Mode FSM; a button event in RUN takes priority over a coincident tick.
    always_comb begin
        state_d    = state_q;
        cnt_en_d   = 1'b0;
        cnt_load_d = 1'b0;
        cnt_down_d = cnt_down_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_start) begin
                    state_d    = ST_RUN;
                    cnt_down_d = 1'b0;
                end else if (rise_load) begin
                    state_d    = ST_PAUSE;
                    cnt_load_d = 1'b1;
                    cnt_down_d = ~load_zero;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rise_start) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (cnt_down_q && cnt_zero) begin
                        state_d = ST_EXPIRED;
                    end else if (STOP_AT_MAX && !cnt_down_q && cnt_max) begin
                        state_d = ST_PAUSE;
                    end else begin
                        cnt_en_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (rise_start) begin
                    state_d = (cnt_down_q && cnt_zero) ? ST_EXPIRED : ST_RUN;
                end else if (rise_load) begin
                    cnt_load_d = 1'b1;
                    cnt_down_d = ~load_zero;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_EXPIRED: begin
                if (rise_start || rise_load) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXPIRED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Expiry blink: starts blanked, toggles every BLINK_TK count ticks.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        if (state_d != ST_EXPIRED) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (state_q != ST_EXPIRED) begin
            blink_cnt_d = '0;
            blank_d     = 1'b1;
        end else if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blank_d     = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Digit scan and anode drive.
    always_comb begin
        dsel_d = dsel_q;
        if (scan_tick) begin
            dsel_d = dsel_q + 2'd1;
        end else begin
            dsel_d = dsel_q;
        end
        an_d = blank_d ? AN_OFF : an_pattern(dsel_d);
    end

    // State and output registers; buttons reset high so a held button is not an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q     <= 1'b1;
            load_q      <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_en_q    <= 1'b0;
            cnt_load_q  <= 1'b0;
            cnt_down_q  <= 1'b0;
            cnt_clr_q   <= 1'b1;
            alarm_q     <= 1'b0;
            dsel_q      <= DIG_D;
            an_q        <= 4'b1110;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            start_q     <= start_btn;
            load_q      <= load_btn;
            state_q     <= state_d;
            cnt_en_q    <= cnt_en_d;
            cnt_load_q  <= cnt_load_d;
            cnt_down_q  <= cnt_down_d;
            cnt_clr_q   <= (state_d == ST_IDLE);
            alarm_q     <= (state_d == ST_EXPIRED);
            dsel_q      <= dsel_d;
            an_q        <= an_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_load  = cnt_load_q;
    assign cnt_down  = cnt_down_q;
    assign cnt_clr   = cnt_clr_q;
    assign alarm     = alarm_q;
    assign digit_sel = dsel_q;
    assign an        = an_q;
    assign state_o   = {1'b0, state_q};

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: two instances (wrap / stop-at-max) share stimulus;
// a behavioural model predicts every cycle's outputs, a monitor pops and compares.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int SD = 2;
    localparam int BT = 2;
    localparam logic [13:0] RST_EXP = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1110};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sb = 1'b0, lb = 1'b0, lz = 1'b0, cz = 1'b0, cm = 1'b0;

    logic       en_w, down_w, ld_w, clr_w, al_w, en_s, down_s, ld_s, clr_s, al_s;
    logic [1:0] ds_w, ds_s;
    logic [3:0] an_w, an_s;
    logic [2:0] st_w, st_s;
    logic [13:0] obs_w, obs_s;

    int checks = 0;
    int errors = 0;

    // Model state per instance (0 = wrap, 1 = stop at max)
    int mode[2], ph[2], ecyc[2], pcnt[2];
    bit mdown[2], psb[2], plb[2];
    logic [13:0] q_w[$];
    logic [13:0] q_s[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLINK_TK(BT), .UP_WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .start_btn(sb), .load_btn(lb), .load_zero(lz),
        .cnt_zero(cz), .cnt_max(cm), .cnt_en(en_w), .cnt_down(down_w), .cnt_load(ld_w),
        .cnt_clr(clr_w), .alarm(al_w), .digit_sel(ds_w), .an(an_w), .state_o(st_w)
    );

    stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .BLINK_TK(BT), .UP_WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .start_btn(sb), .load_btn(lb), .load_zero(lz),
        .cnt_zero(cz), .cnt_max(cm), .cnt_en(en_s), .cnt_down(down_s), .cnt_load(ld_s),
        .cnt_clr(clr_s), .alarm(al_s), .digit_sel(ds_s), .an(an_s), .state_o(st_s)
    );

    assign obs_w = {st_w, en_w, down_w, ld_w, clr_w, al_w, ds_w, an_w};
    assign obs_s = {st_s, en_s, down_s, ld_s, clr_s, al_s, ds_s, an_s};

    task automatic cmp(input string name, input logic [13:0] act, input logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got st=%0d en=%b dn=%b ld=%b clr=%b al=%b ds=%0d an=%b, expected st=%0d en=%b dn=%b ld=%b clr=%b al=%b ds=%0d an=%b",
                     name, $time, act[13:11], act[10], act[9], act[8], act[7], act[6], act[5:4], act[3:0],
                     exp[13:11], exp[10], exp[9], exp[8], exp[7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    // One clock edge of the reference model: returns the outputs visible after the edge.
    task automatic model_step(input int i, input bit uw, output logic [13:0] e);
        bit rs, rl, tick, en, ld, blank;
        int nmode, dsel;
        logic [3:0] anv;
        if (rst) begin
            mode[i] = 0; ph[i] = 0; ecyc[i] = 0; pcnt[i] = 0;
            mdown[i] = 1'b0; psb[i] = 1'b1; plb[i] = 1'b1;
            e = RST_EXP;
            return;
        end
        rs = sb && !psb[i];
        rl = lb && !plb[i] && !rs;
        psb[i] = sb; plb[i] = lb;
        tick = (mode[i] == 1 || mode[i] == 3) && (ph[i] % TD == TD - 1);
        en = 1'b0; ld = 1'b0; nmode = mode[i];
        case (mode[i])
            0: if (rs) begin nmode = 1; mdown[i] = 1'b0; end
               else if (rl) begin nmode = 2; ld = 1'b1; mdown[i] = !lz; end
            1: if (rs) nmode = 2;
               else if (tick) begin
                   if (mdown[i] && cz) nmode = 3;
                   else if (!mdown[i] && !uw && cm) nmode = 2;
                   else en = 1'b1;
               end
            2: if (rs) nmode = (mdown[i] && cz) ? 3 : 1;
               else if (rl) begin ld = 1'b1; mdown[i] = !lz; end
            default: if (rs || rl) nmode = 0;
        endcase
        if (mode[i] == 1 || mode[i] == 3) ph[i]++;
        if (nmode != mode[i] && (nmode == 1 || nmode == 3)) ph[i] = 0;
        if (nmode == 3 && mode[i] != 3) ecyc[i] = 0;
        else if (nmode == 3) ecyc[i]++;
        mode[i] = nmode;
        pcnt[i]++;
        dsel = (pcnt[i] / SD) % 4;
        blank = (nmode == 3) && ((ecyc[i] / (TD * BT)) % 2 == 0);
        anv = 4'b1111;
        if (!blank) anv[dsel] = 1'b0;
        e = {3'(nmode), en, mdown[i], ld, (nmode == 0), (nmode == 3), 2'(dsel), anv};
    endtask

    // Model: predicts outputs at every active edge and queues them.
    initial begin
        logic [13:0] e0, e1;
        forever begin
            @(posedge clk);
            model_step(0, 1'b1, e0); q_w.push_back(e0);
            model_step(1, 1'b0, e1); q_s.push_back(e1);
        end
    end

    // Monitor: pops one expectation per instance per cycle, away from the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_w.size() == 0) begin
                checks++; errors++; $display("FAIL underflow_w t=%0t: queue empty, expected 1 entry", $time);
            end else cmp("out_wrap", obs_w, q_w.pop_front());
            if (q_s.size() == 0) begin
                checks++; errors++; $display("FAIL underflow_s t=%0t: queue empty, expected 1 entry", $time);
            end else cmp("out_stop", obs_s, q_s.pop_front());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Directed scenarios followed by random stimulus.
    initial begin
        sb = 1'b1;
        cyc(3);
        rst = 1'b0;           // start held through reset: no event
        cyc(4);
        sb = 1'b0; cyc(2);
        sb = 1'b1; cyc(1);    // IDLE -> RUN up
        sb = 1'b0; cyc(14);
        sb = 1'b1; cyc(1);    // RUN -> PAUSE
        sb = 1'b0; cyc(6);
        lz = 1'b0; lb = 1'b1; cyc(1);   // load, count down
        lb = 1'b0; cyc(2);
        sb = 1'b1; cyc(1);    // RUN down
        sb = 1'b0; cyc(12);
        cz = 1'b1; cyc(8);    // expire at next tick
        cyc(40);              // blink phases
        lb = 1'b1; cyc(1);    // EXPIRED -> IDLE
        lb = 1'b0; cz = 1'b0; cyc(3);
        lz = 1'b1; lb = 1'b1; cyc(1);   // IDLE -> PAUSE, up
        lb = 1'b0; cyc(3);
        sb = 1'b1; lb = 1'b1; cyc(1);   // simultaneous rises: RUN, no load
        sb = 1'b0; lb = 1'b0; cyc(5);
        cm = 1'b1; cyc(5);    // max at tick: stop instance pauses, wrap keeps running
        cm = 1'b0; cyc(6);
        rst = 1'b1; #1;       // asynchronous reset mid-RUN
        cmp("async_rst_w", obs_w, RST_EXP);
        cmp("async_rst_s", obs_s, RST_EXP);
        cyc(2);
        rst = 1'b0; cyc(8);
        sb = 1'b1; cyc(1);
        sb = 1'b0; cyc(10);
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(15) == 0) sb = ~sb;
            if ($urandom_range(15) == 0) lb = ~lb;
            lz = 1'($urandom_range(1));
            cz = ($urandom_range(7) == 0);
            cm = ($urandom_range(7) == 0);
            rst = ($urandom_range(599) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
